// File: rtl/roe_pkg.sv
// roe_pkg: shared definitions for the instruction fetch path.
//   ADDR_W        default instruction address width
//   INSTR_W       default instruction word width
//   fetch_entry_t one queued fetch: the instruction word and its address
package roe_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 9;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular storage for fetched instructions.
// Ports:
//   clk, init_n  clock (rising edge) and asynchronous active-low reset
//   push, wdata  write wdata at the tail
//   pop          drop the head (ignored when empty)
//   flush        empty the queue and rewind both pointers; wins over push/pop
//   head         registered head entry (meaningful when count != 0)
//   count        number of stored entries, 0..depth
// depth must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
  import roe_pkg::*;
#(
  parameter int  depth   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       init_n,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(depth):0]     count
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  entry_t          mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop cancel out in the count.
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues instruction-memory reads for the program counter and
// buffers the returned words for decode.
// Ports:
//   clk, init_n          clock (rising edge), asynchronous active-low reset
//   pc_addr, pc_valid    next fetch address from the program counter
//   pc_ready             fetch accepted (PC advances on pc_valid && pc_ready)
//   imem_addr, imem_rd   memory read request; data returns one cycle later
//   imem_data            memory read data
//   flush                taken branch: discard queued and in-flight fetches
//   dec_valid/dec_ready  head handshake towards decode
//   dec_instr, dec_addr  head instruction and its address
//   stall_cnt            only with FETCH_QUEUE_STALL_CNT_EN: saturating count
//                        of cycles with pc_valid && !pc_ready
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never depends on ready, and the payload is stable while valid is high.
module fetch_queue
  import roe_pkg::*;
#(
  parameter int addr_w  = ADDR_W,
  parameter int instr_w = INSTR_W,
  parameter int depth   = 4
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [addr_w-1:0]  pc_addr,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic [addr_w-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [instr_w-1:0] imem_data,
  input  logic               flush,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [instr_w-1:0] dec_instr,
  output logic [addr_w-1:0]  dec_addr
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int CW = $clog2(depth) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(depth);

  // Same layout as fetch_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [addr_w-1:0]  addr;
    logic [instr_w-1:0] instr;
  } entry_t;

  logic              issue;
  logic              inflight;
  logic [addr_w-1:0] inflight_addr;
  entry_t            wdata;
  entry_t            head;
  logic [CW-1:0]     count;

  // Credit rule: a slot is reserved for every read in flight, so the queue
  // can never be pushed while full.
  assign pc_ready  = !flush && (({1'b0, count} + (CW + 1)'(inflight)) < DEPTH_C);
  assign issue     = pc_valid && pc_ready;
  assign imem_addr = pc_addr;
  assign imem_rd   = issue;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (flush) begin
      inflight      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_addr <= pc_addr;
    end
  end

  always_comb begin
    wdata       = '0;
    wdata.addr  = inflight_addr;
    wdata.instr = imem_data;
  end

  // The FIFO drops a push during flush, which also discards data returning
  // from a read issued the cycle before the flush.
  fetch_fifo #(
    .depth   (depth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .init_n (init_n),
    .push   (inflight),
    .wdata  (wdata),
    .pop    (dec_ready),
    .flush  (flush),
    .head   (head),
    .count  (count)
  );

  assign dec_valid = (count != '0);
  assign dec_instr = head.instr;
  assign dec_addr  = head.addr;

`ifdef FETCH_QUEUE_STALL_CNT_EN
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      stall_cnt <= '0;
    end else if (pc_valid && !pc_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter addr_w, default 16, meaning instruction address width.
REQ-002 The block SHALL have parameter instr_w, default 9, meaning instruction word width.
REQ-003 The block SHALL have parameter depth, default 4, meaning queue entries; power of two, 2..16.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port init_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port pc_addr, input, addr_w: next fetch address from the program counter.
REQ-007 Port pc_valid, input, 1: pc_addr is valid.
REQ-008 Port pc_ready, output, 1: fetch accepted; the program counter advances only when pc_valid && pc_ready.
REQ-009 Port imem_addr, output, addr_w: instruction memory read address.
REQ-010 Port imem_rd, output, 1: memory read strobe; data returns exactly 1 cycle later.
REQ-011 Port imem_data, input, instr_w: memory read data.
REQ-012 Port flush, input, 1: branch taken (bnz), so all queued and in-flight fetches are discarded.
REQ-013 Port dec_valid, output, 1: the queue head is valid.
REQ-014 Port dec_ready, input, 1: decode consumes the head.
REQ-015 Port dec_instr, output, instr_w: head instruction.
REQ-016 Port dec_addr, output, addr_w: head instruction's address.

Function
REQ-017 pc_ready SHALL be !flush && (count + inflight < depth), combinational.
REQ-018 imem_addr SHALL equal pc_addr and imem_rd SHALL equal pc_valid && pc_ready, combinational.
REQ-019 On issue, the block SHALL register inflight=1 and the issued address; the next cycle imem_data plus that address SHALL be pushed at the tail.
REQ-020 dec_valid SHALL be count!=0; dec_instr and dec_addr SHALL show the head entry, registered storage, with no combinational path from imem_data.
REQ-021 Pop occurs on dec_valid && dec_ready; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 Pointers SHALL wrap modulo depth; count SHALL be $clog2(depth)+1 bits, range 0..depth.
REQ-023 The credit rule (REQ-017) SHALL make a push while full impossible; the bench asserts count<=depth.
REQ-024 When flush=1, the next edge SHALL set count=0, reset both pointers, clear inflight, and suppress any push in that cycle; a pop in the same cycle is ignored.
REQ-025 A read issued in the cycle before flush SHALL have its returning data discarded.
REQ-026 The first issue after flush SHALL occur at the earliest in the cycle after flush deasserts.
REQ-027 Sustained throughput SHALL be 1 instruction/cycle when dec_ready=1 and pc_valid=1; fetch-to-dec_valid latency is 2 cycles.

Reset
REQ-028 While init_n=0, the block SHALL asynchronously force count=0, pointers=0, inflight=0, and stored dec_instr/dec_addr=0, so that dec_valid=0 and pc_ready=1 when flush=0.
REQ-029 Reset mid-operation SHALL drop all entries and the in-flight read; returning data SHALL be ignored.

Configuration
REQ-030 Macro FETCH_QUEUE_STALL_CNT_EN defined: the block SHALL add output stall_cnt, 16 bits, counting cycles with pc_valid && !pc_ready, saturating at 16'hFFFF and cleared by reset only.
REQ-031 Macro FETCH_QUEUE_STALL_CNT_EN undefined: the port and logic SHALL be absent, with function otherwise identical.

Structure
REQ-032 The shared package roe_pkg SHALL hold ADDR_W=16, INSTR_W=9, and typedef fetch_entry_t {addr, instr}.
REQ-033 Storage SHALL be a sub-module fetch_fifo (depth entries of fetch_entry_t, push/pop/flush, count); fetch_queue holds the issue and credit logic.

Verification
REQ-034 Reset then pc_valid=1 with addresses 0,1,2 and dec_ready=1: imem_rd high each cycle, and dec_valid from cycle 2 shows addr 0,1,2 with matching instructions, back-to-back.
REQ-035 dec_ready=0, pc_valid=1: pc_ready drops after 4 issues (3 queued + 1 in-flight, then 4 queued); count=4, no overwrite; raising dec_ready drains in order 0..3.
REQ-036 Queue at 2 entries plus a read in flight, then flush for 1 cycle: next cycle dec_valid=0 and count=0; the stale imem_data is not pushed; pc_addr=0x0040 after flush appears as the first dec_addr.
REQ-037 Simultaneous push and pop with count=2 for 10 cycles: count stays 2 and order is preserved across pointer wrap.
REQ-038 init_n pulsed low mid-stream with 3 entries: dec_valid=0 immediately (asynchronous), with no push on the following cycle.
REQ-039 With FETCH_QUEUE_STALL_CNT_EN defined, holding full for 5 cycles with pc_valid=1 gives stall_cnt=5.
